// File: rtl/core_column_readout_ctrl.sv
// Token-based readout sequencer for one core column: queues L1 trigger IDs, walks the
// region token chain per trigger and streams ToT words plus a trailer over valid/ready.
module core_column_readout_ctrl #(
    parameter int QDEPTH     = 8,
    parameter int TOK_SETTLE = 2,
    parameter int MAX_HITS   = 64
) (
    input  logic                        Clk,
    input  logic                        Reset,
    input  logic                        L1Trig,
    input  logic [4:0]                  TrigId,
    output logic [4:0]                  RegionTrigIdReq,
    output logic                        RegionTokIn,
    input  logic                        RegionTokOut,
    output logic                        RegionRead,
    input  logic [15:0]                 RegionData,
    output logic                        OutValid,
    input  logic                        OutReady,
    output logic [22:0]                 OutData,
    output logic [$clog2(QDEPTH):0]     QueueLevel,
    output logic                        Overflow
);

    localparam int AW = $clog2(QDEPTH);
    localparam int LW = AW + 1;
    localparam int HW = $clog2(MAX_HITS + 1);
    localparam int SW = (TOK_SETTLE > 1) ? $clog2(TOK_SETTLE) : 1;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SETTLE  = 3'd1,
        S_READ    = 3'd2,
        S_PUSH    = 3'd3,
        S_TRAILER = 3'd4
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [4:0]      r_mem [QDEPTH];
    logic [AW-1:0]   r_wptr;
    logic [AW-1:0]   r_rptr;
    logic [LW-1:0]   r_level;
    logic            r_ovf;
    logic [4:0]      r_cur_id;
    logic [HW-1:0]   r_hit_cnt;
    logic            r_trunc;
    logic [SW-1:0]   r_settle;
    logic [15:0]     r_data;
    logic            w_full;
    logic            w_empty;
    logic            w_push;
    logic            w_pop;
    logic            w_hit_room;

    assign w_full     = (r_level == LW'(QDEPTH));
    assign w_empty    = (r_level == {LW{1'b0}});
    // A pop in the same cycle never frees room for a push into a full queue.
    assign w_push     = L1Trig & ~w_full;
    assign w_pop      = (r_state == S_IDLE) & ~w_empty;
    assign w_hit_room = (r_hit_cnt < HW'(MAX_HITS));

    // Trigger-ID storage; contents need no reset because the pointers define validity.
    always_ff @(posedge Clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= TrigId;
        end
    end

    // Queue pointers, occupancy and overflow pulse.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_wptr  <= {AW{1'b0}};
            r_rptr  <= {AW{1'b0}};
            r_level <= {LW{1'b0}};
            r_ovf   <= 1'b0;
        end else begin
            r_ovf <= L1Trig & w_full;
            if (w_push) begin
                r_wptr <= r_wptr + AW'(1'b1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + AW'(1'b1);
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LW'(1'b1);
                2'b01:   r_level <= r_level - LW'(1'b1);
                default: r_level <= r_level;
            endcase
        end
    end

    // FSM state register.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // FSM next-state logic.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    w_next = S_SETTLE;
                end else begin
                    w_next = S_IDLE;
                end
            end
            S_SETTLE: begin
                if (r_settle != {SW{1'b0}}) begin
                    w_next = S_SETTLE;
                end else if (RegionTokOut) begin
                    w_next = S_TRAILER;
                end else begin
                    w_next = S_READ;
                end
            end
            S_READ: begin
                if (w_hit_room) begin
                    w_next = S_PUSH;
                end else begin
                    w_next = S_SETTLE;
                end
            end
            S_PUSH: begin
                if (OutReady) begin
                    w_next = S_SETTLE;
                end else begin
                    w_next = S_PUSH;
                end
            end
            S_TRAILER: begin
                if (OutReady) begin
                    w_next = S_IDLE;
                end else begin
                    w_next = S_TRAILER;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Per-trigger datapath: current ID, hit counter, truncation flag, settle timer, captured word.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_cur_id  <= 5'd0;
            r_hit_cnt <= {HW{1'b0}};
            r_trunc   <= 1'b0;
            r_settle  <= {SW{1'b0}};
            r_data    <= 16'h0000;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (!w_empty) begin
                        r_cur_id  <= r_mem[r_rptr];
                        r_hit_cnt <= {HW{1'b0}};
                        r_trunc   <= 1'b0;
                        r_settle  <= SW'(TOK_SETTLE - 1);
                    end
                end
                S_SETTLE: begin
                    if (r_settle != {SW{1'b0}}) begin
                        r_settle <= r_settle - SW'(1'b1);
                    end
                end
                S_READ: begin
                    r_data <= RegionData;
                    if (w_hit_room) begin
                        r_hit_cnt <= r_hit_cnt + HW'(1'b1);
                    end else begin
                        r_trunc  <= 1'b1;
                        r_settle <= SW'(TOK_SETTLE - 1);
                    end
                end
                S_PUSH: begin
                    if (OutReady) begin
                        r_settle <= SW'(TOK_SETTLE - 1);
                    end
                end
                default: begin
                    r_settle <= r_settle;
                end
            endcase
        end
    end

    // The token stays in the chain while a word waits downstream, so the read region keeps it.
    assign RegionTokIn     = (r_state == S_SETTLE) | (r_state == S_READ) | (r_state == S_PUSH);
    assign RegionRead      = (r_state == S_READ);
    assign OutValid        = (r_state == S_PUSH) | (r_state == S_TRAILER);
    assign RegionTrigIdReq = r_cur_id;
    assign QueueLevel      = r_level;
    assign Overflow        = r_ovf;

    // Output word formatting from registered state only, so it is stable during a stall.
    always_comb begin
        OutData = 23'd0;
        case (r_state)
            S_PUSH:    OutData = {1'b0, r_cur_id, 1'b0, r_data};
            S_TRAILER: OutData = {1'b1, r_cur_id, r_trunc, 16'(r_hit_cnt)};
            default:   OutData = 23'd0;
        endcase
    end

endmodule
